// File: rtl/imem_boot_loader_if.sv
// Byte link, imem write port and core-control bundle for imem_boot_loader.
// The slave modport is the loader side; the master modport is the host/monitor side.
interface imem_boot_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_reset;
  logic              done;
  logic              error;
  logic [15:0]       word_cnt;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error, word_cnt
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata, cpu_reset, done, error, word_cnt
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: frames SYNC, LEN_LO, LEN_HI, 4*LEN little-endian data bytes into imem, then releases the core.
// Optional trailing XOR checksum byte is enabled with `define IMEM_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  imem_boot_loader_if.slave bus
);

`ifdef IMEM_CHECKSUM_EN
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_LEN_LO = 4'd1, ST_LEN_HI = 4'd2, ST_DATA = 4'd3,
    ST_WR   = 4'd4, ST_FIN    = 4'd5, ST_RUN    = 4'd6, ST_ERR  = 4'd7,
    ST_CHK  = 4'd8
  } state_t;
  localparam state_t ST_END = ST_CHK;

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
`else
  typedef enum logic [3:0] {
    ST_IDLE = 4'd0, ST_LEN_LO = 4'd1, ST_LEN_HI = 4'd2, ST_DATA = 4'd3,
    ST_WR   = 4'd4, ST_FIN    = 4'd5, ST_RUN    = 4'd6, ST_ERR  = 4'd7
  } state_t;
  localparam state_t ST_END = ST_FIN;
`endif

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       data_q, data_d;
  logic [15:0]       word_cnt_q, word_cnt_d;
  logic              rx_ready_q, rx_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
`ifdef IMEM_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              accept_s;
  logic              is_sync_s;
  logic [15:0]       len_s;

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign bus.cpu_reset  = cpu_reset_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.word_cnt   = word_cnt_q;

  // State register and registered outputs; async reset aborts any frame in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_lo_q     <= 8'h00;
      len_q        <= 16'h0000;
      byte_cnt_q   <= 2'd0;
      data_q       <= 24'h000000;
      word_cnt_q   <= 16'h0000;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h0000_0000;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
      csum_q       <= 8'h00;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      data_q       <= data_d;
      word_cnt_q   <= word_cnt_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
`ifdef IMEM_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  // Next-state and next-output logic; outputs are decoded from the next state so they register cleanly.
  always_comb begin
    accept_s     = bus.rx_valid & rx_ready_q;
    is_sync_s    = accept_s && (bus.rx_data == SYNC_BYTE);
    len_s        = {bus.rx_data, len_lo_q};
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    data_d       = data_q;
    word_cnt_d   = word_cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
`ifdef IMEM_CHECKSUM_EN
    csum_d       = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (is_sync_s) begin
          state_d    = ST_LEN_LO;
          word_cnt_d = 16'h0000;
          byte_cnt_d = 2'd0;
`ifdef IMEM_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_lo_d = bus.rx_data;
          state_d  = ST_LEN_HI;
        end else begin
          state_d = state_q;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          len_d = len_s;
          if ({1'b0, len_s} > CAPACITY) begin
            state_d = ST_ERR;
          end else if (len_s == 16'h0000) begin
            state_d = ST_END;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DATA: begin
        // SYNC_BYTE values are ordinary payload here.
        if (accept_s) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          data_d     = {bus.rx_data, data_q[23:8]};
`ifdef IMEM_CHECKSUM_EN
          csum_d     = csum_fold(csum_q, bus.rx_data);
`endif
          if (byte_cnt_q == 2'd3) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[ADDR_W-1:0];
            imem_wdata_d = {bus.rx_data, data_q};
            state_d      = ST_WR;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_WR: begin
        word_cnt_d = word_cnt_q + 16'd1;
        if ((word_cnt_q + 16'd1) == len_q) begin
          state_d = ST_END;
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_FIN: begin
        state_d = ST_RUN;
      end
`ifdef IMEM_CHECKSUM_EN
      ST_CHK: begin
        if (accept_s) begin
          if (bus.rx_data == csum_q) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = state_q;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rx_ready_d  = (state_d != ST_WR);
    cpu_reset_d = (state_d != ST_RUN);
    done_d      = (state_d == ST_RUN);
    error_d     = (state_d == ST_ERR);
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: a table of byte/idle vectors with expected outputs,
// plus hand sequences for length overflow, full-capacity frame, checksum and mid-frame reset.
module tb_imem_boot_loader;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  imem_boot_loader_if #(.ADDR_W(8)) bus ();

  imem_boot_loader #(.ADDR_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        drive;
    logic [7:0]  data;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        rdy;
    logic        crst;
    logic        done;
    logic        err;
    logic [15:0] wc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_wr     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic drive, input logic [7:0] d, input logic we,
                              input logic [7:0] a, input logic [31:0] w, input logic rdy,
                              input logic crst, input logic dn, input logic er, input logic [15:0] wc);
    vec_t v;
    v.drive = drive; v.data = d; v.we = we; v.addr = a; v.wdata = w;
    v.rdy = rdy; v.crst = crst; v.done = dn; v.err = er; v.wc = wc;
    return v;
  endfunction

  // Row without a write: rx_ready expected high.
  function automatic vec_t nw(input logic drive, input logic [7:0] d, input logic crst,
                              input logic dn, input logic er, input logic [15:0] wc);
    return mk(drive, d, 1'b0, 8'h00, 32'h0, 1'b1, crst, dn, er, wc);
  endfunction

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    guard = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_ready_timeout: got %b expected 1", bus.rx_ready);
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic chk_outs(input string tag, input logic we, input logic [7:0] a, input logic [31:0] w,
                          input logic rdy, input logic crst, input logic dn, input logic er,
                          input logic [15:0] wc);
    chk({tag, ".we"},        32'(bus.imem_we),   32'(we));
    chk({tag, ".rx_ready"},  32'(bus.rx_ready),  32'(rdy));
    chk({tag, ".cpu_reset"}, 32'(bus.cpu_reset), 32'(crst));
    chk({tag, ".done"},      32'(bus.done),      32'(dn));
    chk({tag, ".error"},     32'(bus.error),     32'(er));
    chk({tag, ".word_cnt"},  32'(bus.word_cnt),  32'(wc));
    if (we) begin
      chk({tag, ".addr"},  32'(bus.imem_addr), 32'(a));
      chk({tag, ".wdata"}, bus.imem_wdata,     w);
    end
  endtask

  // Write monitor: counts strobes and checks the write bubble.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      n_wr++;
      chk("write_bubble_rx_ready", 32'(bus.rx_ready), 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] kb;
    int exp_wr;

    // T3: junk in IDLE, then one word containing DEADBEEF
    vecs.push_back(nw(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'hEF, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'hBE, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'hAD, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b1, 8'hDE, 1'b1, 8'h00, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
`ifdef IMEM_CHECKSUM_EN
    vecs.push_back(nw(1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 16'd1));
`else
    vecs.push_back(nw(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd1));
    vecs.push_back(nw(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd1));
`endif
    // T2: reload from RUN, two words
    vecs.push_back(nw(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(mk(1'b1, 8'h00, 1'b1, 8'h00, 32'h00500013, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h93, 1'b1, 1'b0, 1'b0, 16'd1));
    vecs.push_back(nw(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd1));
    vecs.push_back(nw(1'b1, 8'h10, 1'b1, 1'b0, 1'b0, 16'd1));
    vecs.push_back(mk(1'b1, 8'h00, 1'b1, 8'h01, 32'h00100093, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1));
`ifdef IMEM_CHECKSUM_EN
    vecs.push_back(nw(1'b1, 8'hC0, 1'b0, 1'b1, 1'b0, 16'd2));
`else
    vecs.push_back(nw(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd2));
    vecs.push_back(nw(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd2));
`endif
    // junk in RUN is discarded
    vecs.push_back(nw(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'd2));
    vecs.push_back(nw(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 16'd2));
    // T5: zero-length reload
    vecs.push_back(nw(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0));
    vecs.push_back(nw(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0));
`ifdef IMEM_CHECKSUM_EN
    vecs.push_back(nw(1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0));
`else
    vecs.push_back(nw(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'd0));
`endif

    // T1 part 1: reset values
    reset        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_outs("reset", 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("reset.addr",  32'(bus.imem_addr), 32'd0);
    chk("reset.wdata", bus.imem_wdata,     32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk_outs("release", 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].drive) begin
        send_byte(vecs[i].data);
      end else begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
      chk_outs($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].rdy,
               vecs[i].crst, vecs[i].done, vecs[i].err, vecs[i].wc);
    end

    // T4: LEN=257 overflows capacity
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    chk_outs("t4_err", 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0);
    send_byte(8'h00);
    chk_outs("t4_err_hold", 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd0);
    send_byte(8'hA5);
    chk_outs("t4_clear", 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);

    // LEN=256: full capacity, SYNC value used as payload in every word
    send_byte(8'h00);
    send_byte(8'h01);
    chk_outs("cap_len", 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      send_byte(8'hA5);
      send_byte(kb);
      send_byte(~kb);
      send_byte(8'h3C);
      chk_outs($sformatf("cap_w%0d", k), 1'b1, kb, {8'h3C, ~kb, kb, 8'hA5}, 1'b0, 1'b1, 1'b0, 1'b0,
               16'(k));
    end
`ifdef IMEM_CHECKSUM_EN
    send_byte(8'h00);
    chk_outs("cap_run", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd256);
`else
    @(negedge clk);
    chk_outs("cap_fin", 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd256);
    @(negedge clk);
    chk_outs("cap_run", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd256);
`endif

`ifdef IMEM_CHECKSUM_EN
    // T6: checksum 01^02^04^08 = 0F
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    chk_outs("t6_w", 1'b1, 8'h00, 32'h08040201, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    send_byte(8'h0F);
    chk_outs("t6_good", 1'b0, 8'h00, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h0E);
    chk_outs("t6_bad", 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 16'd1);
`endif

    // T1 part 2: async reset in the middle of a frame
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE);
    #2 reset = 1'b0;
    #1;
    chk_outs("mid_reset", 1'b0, 8'h00, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
    chk("mid_reset.addr",  32'(bus.imem_addr), 32'd0);
    chk("mid_reset.wdata", bus.imem_wdata,     32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_outs("mid_release", 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    send_byte(8'hDE); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    chk_outs("mid_idle", 1'b0, 8'h00, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);

`ifdef IMEM_CHECKSUM_EN
    exp_wr = 261;
`else
    exp_wr = 259;
`endif
    chk("total_writes", 32'(n_wr), 32'(exp_wr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
